// File: rtl/flash_port_arb.sv
// Arbitrates the single-port flash between instruction fetch (IF) and data port (DP), routing in-order read data back by owner ID.
// Optional bus lock for DP is compiled in with `define FLASH_ARB_LOCK_EN.
module flash_port_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_OUTS   = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_ready,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  dp_req,
    input  logic                  dp_we,
    input  logic [ADDR_W-1:0]     dp_addr,
    input  logic [DATA_W-1:0]     dp_wdata,
    input  logic [DATA_W/8-1:0]   dp_be,
    input  logic                  dp_lock,
    output logic                  dp_ready,
    output logic                  dp_rvalid,
    output logic [DATA_W-1:0]     dp_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  arb_err
);
    localparam int PTR_W = $clog2(MAX_OUTS);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    logic [MAX_OUTS-1:0] own_q, own_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SC_W-1:0]     starve_q, starve_d;
    logic                err_q, err_d;
    logic                lock_blk;

    logic full, empty, starved, if_win, win_req, win_rd, stall;
    logic mem_go, accept, push, pop, head;

`ifdef FLASH_ARB_LOCK_EN
    logic lock_q, lock_d;
    assign lock_blk = lock_q;
`else
    logic unused_lock;
    assign unused_lock = dp_lock;
    assign lock_blk    = 1'b0;
`endif

    always_comb begin
        full    = (cnt_q == CNT_W'(MAX_OUTS));
        empty   = (cnt_q == '0);
        starved = (starve_q == SC_W'(STARVE_MAX));
        if_win  = if_req & (~dp_req | starved) & ~lock_blk;
        win_req = if_win | dp_req;
        win_rd  = if_win | ~dp_we;
        stall   = full & win_rd;
        mem_go  = win_req & ~stall & ~cpu_rst;
        accept  = mem_go & mem_ready;
        push    = accept & win_rd;
        pop     = mem_rvalid & ~empty & ~cpu_rst;
        head    = own_q[rd_ptr_q];
    end

    // Request side: all outputs forced low while reset is asserted
    assign mem_req   = mem_go;
    assign mem_we    = ~cpu_rst & ~if_win & dp_we;
    assign mem_addr  = cpu_rst ? '0 : (if_win ? if_addr : dp_addr);
    assign mem_wdata = (cpu_rst | if_win) ? '0 : dp_wdata;
    assign mem_be    = (cpu_rst | if_win) ? '0 : dp_be;
    assign if_ready  = accept & if_win;
    assign dp_ready  = accept & ~if_win;

    // Response side: in-order data steered by the owner at the FIFO head
    assign if_rvalid = pop & ~head;
    assign dp_rvalid = pop & head;
    assign if_rdata  = (pop & ~head) ? mem_rdata : '0;
    assign dp_rdata  = (pop & head) ? mem_rdata : '0;
    assign arb_err   = err_q & ~cpu_rst;

    always_comb begin
        own_d    = own_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        starve_d = starve_q;
        err_d    = err_q | (mem_rvalid & empty);
        if (push) begin
            own_d[wr_ptr_q] = ~if_win;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (!lock_blk) begin
            if (!if_req || if_ready) begin
                starve_d = '0;
            end else if (dp_ready && !starved) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

`ifdef FLASH_ARB_LOCK_EN
    always_comb begin
        lock_d = lock_q;
        if (dp_ready) begin
            lock_d = dp_lock;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // Owner IDs are only read when the count says they are valid
    always_ff @(posedge cpu_clk) begin
        own_q <= own_d;
    end
endmodule

// File: tb/tb_flash_port_arb.sv
// Bench for flash_port_arb: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_flash_port_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;
    localparam int SM = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, if_req, dp_req, dp_we, dp_lock, mem_ready, mem_rvalid;
    logic [AW-1:0] if_addr, dp_addr;
    logic [DW-1:0] dp_wdata, mem_rdata;
    logic [3:0]    dp_be;
    logic          if_ready, if_rvalid, dp_ready, dp_rvalid, mem_req, mem_we, arb_err;
    logic [DW-1:0] if_rdata, dp_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;

    flash_port_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTS(MO), .STARVE_MAX(SM)) dut (
        .cpu_clk(clk), .cpu_rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
        .dp_be(dp_be), .dp_lock(dp_lock), .dp_ready(dp_ready),
        .dp_rvalid(dp_rvalid), .dp_rdata(dp_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .arb_err(arb_err)
    );

    // Reference model state
    bit q[$];
    int starve;
    bit err, lockm;
    bit ifw, rd, acc;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        if_req = 0; if_addr = '0; dp_req = 0; dp_we = 0; dp_addr = '0;
        dp_wdata = '0; dp_be = '0; dp_lock = 0; mem_ready = 0;
        mem_rvalid = 0; mem_rdata = '0;
    endtask

    // Mid-cycle: compute required outputs from the model and compare
    task automatic settle();
        bit mreq, rv, own;
        #4;
        ifw = 0; rd = 0; acc = 0; mreq = 0; rv = 0; own = 0;
        if (!rst) begin
            ifw  = if_req && (!dp_req || starve >= SM) && !lockm;
            rd   = ifw || !dp_we;
            mreq = (ifw || dp_req) && !(q.size() == MO && rd);
            acc  = mreq && mem_ready;
            rv   = mem_rvalid && q.size() > 0;
            if (rv) own = q[0];
        end
        chk("mem_req", mem_req, mreq);
        chk("if_ready", if_ready, acc && ifw);
        chk("dp_ready", dp_ready, acc && !ifw);
        chk("mem_addr", mem_addr, rst ? '0 : (ifw ? if_addr : dp_addr));
        chk("mem_we", mem_we, !rst && !ifw && dp_we);
        chk("mem_wdata", mem_wdata, (rst || ifw) ? '0 : dp_wdata);
        chk("mem_be", mem_be, (rst || ifw) ? '0 : dp_be);
        chk("if_rvalid", if_rvalid, rv && !own);
        chk("dp_rvalid", dp_rvalid, rv && own);
        chk("if_rdata", if_rdata, (rv && !own) ? mem_rdata : '0);
        chk("dp_rdata", dp_rdata, (rv && own) ? mem_rdata : '0);
        chk("arb_err", arb_err, !rst && err);
    endtask

    // Clock edge: advance the model, then return 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            q.delete(); starve = 0; err = 0; lockm = 0;
        end else begin
            if (mem_rvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else err = 1;
            end
            if (acc && rd) q.push_back(!ifw);
            if (!lockm) begin
                if (!if_req || (acc && ifw)) starve = 0;
                else if (acc && !ifw && starve < SM) starve++;
            end
`ifdef FLASH_ARB_LOCK_EN
            if (acc && !ifw) lockm = dp_lock;
`endif
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        repeat (2) begin settle(); tick(); end
        rst = 0;
    endtask

    int  first, n;
    bit  ifr, dpr;
    bit  dpr_log [20];

    initial begin
        idle();
        rst = 1;
        q.delete(); starve = 0; err = 0; lockm = 0;

        // Reset with both masters requesting
        if_req = 1; dp_req = 1; if_addr = 32'h100; dp_addr = 32'h2000;
        repeat (2) begin
            settle();
            chk("rst_mem_req", mem_req, 0);
            chk("rst_dp_ready", dp_ready, 0);
            tick();
        end
        rst = 0;
        settle();
        chk("post_rst_req", mem_req, 1);
        chk("post_rst_addr", mem_addr, 32'h2000);
        tick();

        // Concurrent IF and DP reads, responses in order
        mem_ready = 1;
        settle();
        chk("conc_dp_first", dp_ready, 1);
        chk("conc_dp_addr", mem_addr, 32'h2000);
        tick();
        dp_req = 0;
        settle();
        chk("conc_if_second", if_ready, 1);
        chk("conc_if_addr", mem_addr, 32'h100);
        tick();
        if_req = 0; mem_rvalid = 1; mem_rdata = 32'hD0D0_0000;
        settle();
        chk("resp0_dp", dp_rvalid, 1);
        chk("resp0_data", dp_rdata, 32'hD0D0_0000);
        tick();
        mem_rdata = 32'hD1D1_1111;
        settle();
        chk("resp1_if", if_rvalid, 1);
        chk("resp1_data", if_rdata, 32'hD1D1_1111);
        tick();

        // Starvation guard with DP streaming writes
        do_reset();
        mem_ready = 1; dp_req = 1; dp_we = 1; dp_addr = 32'h3000; dp_be = 4'hF;
        if_req = 1; if_addr = 32'h104; first = -1;
        for (int c = 0; c < 20; c++) begin
            dp_wdata = $urandom;
            settle();
            dpr_log[c] = dp_ready;
            ifr = if_ready;
            if (ifr && first < 0) first = c;
            tick();
            if (ifr) if_req = 0;
        end
        chk("starve_if_cycle", first, 8);
        chk("starve_dp_before", dpr_log[7], 1);
        chk("starve_dp_resume", dpr_log[9], 1);

        // Owner FIFO full stalls reads, not writes
        do_reset();
        mem_ready = 1; dp_req = 1; dp_we = 0; dp_addr = 32'h4000;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("fill_ready", dp_ready, 1);
            tick();
        end
        settle();
        chk("full_mem_req", mem_req, 0);
        chk("full_dp_ready", dp_ready, 0);
        tick();
        dp_we = 1; dp_wdata = 32'hCAFE_F00D; dp_be = 4'hF;
        settle();
        chk("full_wr_ready", dp_ready, 1);
        chk("full_wr_data", mem_wdata, 32'hCAFE_F00D);
        tick();
        dp_we = 0; dp_wdata = '0; dp_be = '0; mem_rvalid = 1; mem_rdata = 32'h55;
        settle();
        chk("pop_stall", dp_ready, 0);
        chk("pop_rvalid", dp_rvalid, 1);
        tick();
        mem_rvalid = 0;
        settle();
        chk("refill_ready", dp_ready, 1);
        tick();

        // Response with empty owner FIFO
        do_reset();
        mem_rvalid = 1; mem_rdata = 32'hBAD;
        settle();
        chk("err_if_rvalid", if_rvalid, 0);
        chk("err_dp_rvalid", dp_rvalid, 0);
        tick();
        mem_rvalid = 0;
        repeat (3) begin
            settle();
            chk("err_sticky", arb_err, 1);
            tick();
        end
        rst = 1;
        settle(); tick();
        rst = 0;
        settle();
        chk("err_cleared", arb_err, 0);
        tick();

        // DP locked write burst followed by an unlocking write
        do_reset();
        mem_ready = 1; if_req = 1; if_addr = 32'h108;
        dp_req = 1; dp_we = 1; dp_be = 4'h3; dp_addr = 32'h5000; dp_lock = 1;
        n = 0; first = -1;
        for (int c = 0; c < 30; c++) begin
            dp_wdata = $urandom;
            settle();
            ifr = if_ready; dpr = dp_ready;
            if (ifr && first < 0) first = c;
            tick();
            if (ifr) if_req = 0;
            if (dpr) begin
                n++;
                if (n == 11) dp_req = 0;
                dp_lock = (n < 10);
            end
        end
`ifdef FLASH_ARB_LOCK_EN
        chk("lock_if_cycle", first, 11);
`else
        chk("lock_if_cycle", first, 8);
`endif

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (!if_req && $urandom_range(2) == 0) begin
                if_req = 1; if_addr = $urandom;
            end
            if (!dp_req && $urandom_range(2) != 0) begin
                dp_req = 1; dp_we = $urandom_range(1); dp_addr = $urandom;
                dp_wdata = $urandom; dp_be = 4'($urandom);
                dp_lock = ($urandom_range(3) == 0);
            end
            mem_ready  = ($urandom_range(3) != 0);
            mem_rvalid = (q.size() > 0) && ($urandom_range(1) == 1);
            mem_rdata  = $urandom;
            rst        = (c % 997 == 500);
            settle();
            ifr = if_ready; dpr = dp_ready;
            tick();
            if (ifr) if_req = 0;
            if (dpr) dp_req = 0;
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
